// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings, default baud divider
// and the ASCII control codes the monitor decoder reacts to.
package uart_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_STOP   = 3'd3,
    S_WAITHI = 3'd4
  } rx_state_e;

  // 50 MHz clock, 115200 baud
  localparam int BAUD_DIV_DEF = 434;

  localparam logic [7:0] ASCII_CR   = 8'h0d;
  localparam logic [7:0] ASCII_CTLC = 8'h03;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for an asynchronous level input.
// Reset value is selectable so idle-high lines do not glitch out of reset.
module uart_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic s1_q;
  logic s2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= RST_VAL;
      s2_q <= RST_VAL;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

endmodule

// File: rtl/uart_rx_deser.sv
// 8N1 UART receiver: mid-bit sampling, one-cycle rout_en on a good
// frame, one-cycle frame_err on a low stop bit.
import uart_pkg::*;

module uart_rx_deser #(
  parameter int BAUD_DIV = BAUD_DIV_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_in,
  output logic [7:0] rout,
  output logic       rout_en,
  output logic       frame_err,
  output logic       rx_busy
);

  localparam int HALF_DIV = BAUD_DIV / 2;
  localparam int CW       = $clog2(BAUD_DIV);

  localparam logic [CW-1:0] FULL_LD = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] HALF_LD = CW'(HALF_DIV - 1);

  logic rx_s;

  rx_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    rout_q, rout_d;
  logic          en_q, en_d;
  logic          err_q, err_d;
  logic          tick;

  uart_sync2 #(.RST_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (rx_in),
    .q_o (rx_s)
  );

  assign tick = (cnt_q == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      rout_q  <= '0;
      en_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      rout_q  <= rout_d;
      en_q    <= en_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    rout_d  = rout_q;
    en_d    = 1'b0;
    err_d   = 1'b0;
    if (state_q != S_IDLE) begin
      cnt_d = cnt_q - CW'(1);
    end
    unique case (state_q)
      S_IDLE: begin
        if (!rx_s) begin
          state_d = S_START;
          cnt_d   = HALF_LD;
        end
      end
      S_START: begin
        // a start that has gone high by mid-bit is a glitch
        if (tick) begin
          if (!rx_s) begin
            state_d = S_DATA;
            cnt_d   = FULL_LD;
            idx_d   = '0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_DATA: begin
        if (tick) begin
          shift_d = {rx_s, shift_q[7:1]};
          cnt_d   = FULL_LD;
          if (idx_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      S_STOP: begin
        if (tick) begin
          if (rx_s) begin
            rout_d  = shift_q;
            en_d    = 1'b1;
            state_d = S_IDLE;
          end else begin
            err_d   = 1'b1;
            state_d = S_WAITHI;
          end
        end
      end
      S_WAITHI: begin
        // a held-low (break) line must not look like a new start
        if (rx_s) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign rout      = rout_q;
  assign rout_en   = en_q;
  assign frame_err = err_q;
  assign rx_busy   = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_deser.sv
// Directed bench for uart_rx_deser at BAUD_DIV=8: table of frames
// plus hand sequences for back-to-back, glitch and mid-frame reset.
module tb_uart_rx_deser;

  localparam int BD = 8;

  logic       clk;
  logic       rst;
  logic       rx_in;
  logic [7:0] rout;
  logic       rout_en;
  logic       frame_err;
  logic       rx_busy;

  int n_pass;
  int n_tot;
  int cyc;
  int err_cnt;
  int wide_cnt;
  int excl_cnt;
  logic prev_en;
  logic prev_err;
  logic [7:0] byte_q[$];
  int         cyc_q[$];

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         hold;
    int         exp_en;
    int         exp_err;
    logic [7:0] exp_rout;
  } vec_t;

  vec_t vecs[5];

  uart_rx_deser #(.BAUD_DIV(BD)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_in     (rx_in),
    .rout      (rout),
    .rout_en   (rout_en),
    .frame_err (frame_err),
    .rx_busy   (rx_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    err_cnt  = 0;
    wide_cnt = 0;
    excl_cnt = 0;
    prev_en  = 1'b0;
    prev_err = 1'b0;
  end

  always @(negedge clk) begin
    if (rout_en === 1'b1) begin
      byte_q.push_back(rout);
      cyc_q.push_back(cyc);
      if (prev_en) wide_cnt++;
    end
    if (frame_err === 1'b1) begin
      err_cnt++;
      if (prev_err) wide_cnt++;
    end
    if (rout_en === 1'b1 && frame_err === 1'b1)
      excl_cnt++;
    prev_en  = (rout_en === 1'b1);
    prev_err = (frame_err === 1'b1);
  end

  task automatic chk(input string nm,
                     input int act,
                     input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d want %0d",
                  nm, act, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    rx_in = b;
    idle(BD);
  endtask

  task automatic send_frame(input logic [7:0] d,
                            input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(stop);
  endtask

  initial begin
    int n0;
    int e0;
    logic [7:0] a5;
    n_pass = 0;
    n_tot  = 0;

    vecs[0] = '{8'h67, 1'b1, 0,  1, 0, 8'h67};
    vecs[1] = '{8'h55, 1'b0, 40, 0, 1, 8'h67};
    vecs[2] = '{8'h31, 1'b1, 0,  1, 0, 8'h31};
    vecs[3] = '{8'hFF, 1'b1, 0,  1, 0, 8'hFF};
    vecs[4] = '{8'h00, 1'b1, 0,  1, 0, 8'h00};

    rst   = 1'b1;
    rx_in = 1'b1;
    idle(3);
    rst = 1'b0;
    chk("rst_rout", int'(rout), 0);
    chk("rst_en", int'(rout_en), 0);
    chk("rst_err", int'(frame_err), 0);
    chk("rst_busy", int'(rx_busy), 0);
    idle(4);

    for (int v = 0; v < 5; v++) begin
      n0 = byte_q.size();
      e0 = err_cnt;
      send_frame(vecs[v].data, vecs[v].stop);
      if (!vecs[v].stop) begin
        idle(vecs[v].hold / 2);
        chk($sformatf("v%0d_hold_busy", v),
            int'(rx_busy), 1);
        idle(vecs[v].hold - vecs[v].hold / 2);
        rx_in = 1'b1;
      end
      idle(12);
      chk($sformatf("v%0d_en", v),
          byte_q.size() - n0, vecs[v].exp_en);
      chk($sformatf("v%0d_err", v),
          err_cnt - e0, vecs[v].exp_err);
      chk($sformatf("v%0d_rout", v),
          int'(rout), int'(vecs[v].exp_rout));
      chk($sformatf("v%0d_busy", v),
          int'(rx_busy), 0);
    end

    // back-to-back 03 then 0d, no idle gap
    n0 = byte_q.size();
    send_frame(8'h03, 1'b1);
    send_frame(8'h0d, 1'b1);
    idle(12);
    chk("b2b_cnt", byte_q.size() - n0, 2);
    if (byte_q.size() - n0 == 2) begin
      chk("b2b_b0", int'(byte_q[n0]), 8'h03);
      chk("b2b_b1", int'(byte_q[n0 + 1]), 8'h0d);
      chk("b2b_gap", cyc_q[n0 + 1] - cyc_q[n0], 80);
    end

    // 3-cycle low glitch
    n0 = byte_q.size();
    e0 = err_cnt;
    rx_in = 1'b0;
    idle(3);
    rx_in = 1'b1;
    idle(20);
    chk("gl_en", byte_q.size() - n0, 0);
    chk("gl_err", err_cnt - e0, 0);
    chk("gl_rout", int'(rout), 8'h0d);
    chk("gl_busy", int'(rx_busy), 0);

    // reset during data bit 4 of A5
    n0 = byte_q.size();
    e0 = err_cnt;
    a5 = 8'hA5;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(a5[i]);
    rx_in = a5[4];
    idle(4);
    rx_in = 1'b1;
    rst   = 1'b1;
    idle(1);
    rst = 1'b0;
    chk("mr_rout", int'(rout), 0);
    chk("mr_en", int'(rout_en), 0);
    chk("mr_err", int'(frame_err), 0);
    chk("mr_busy", int'(rx_busy), 0);
    idle(90);
    chk("mr_quiet", byte_q.size() - n0, 0);
    send_frame(8'h72, 1'b1);
    idle(12);
    chk("mr_en72", byte_q.size() - n0, 1);
    chk("mr_rout72", int'(rout), 8'h72);
    chk("mr_errs", err_cnt - e0, 0);

    chk("pulse_wide", wide_cnt, 0);
    chk("pulse_excl", excl_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/uart_rx_deser.md
Name: uart_rx_deser

Overview:
- Serial UART receiver that sits directly upstream of the monitor command decoder.
- Synchronises the asynchronous RX pin, detects and verifies the start bit, and samples 8 data bits LSB-first at mid-bit, then checks the stop bit.
- On a valid frame it presents the byte on rout with a one-cycle rout_en pulse, which is the exact interface the decoder consumes.
- Framing errors are flagged separately and never produce rout_en.

Parameters:
- BAUD_DIV, 434, clk cycles per bit (50 MHz / 115200). Must be >= 4.
- HALF_DIV, BAUD_DIV/2, cycles from start-edge detection to the start-bit mid-sample. Derived; not overridden.

Ports:
- clk  in  1  system clock; the only clock.
- rst  in  1  reset; synchronous, active-high.
- rx_in  in  1  asynchronous serial line; idle high.
- rout  out  8  last correctly received byte; held until the next valid frame.
- rout_en  out  1  one-cycle pulse; rout is valid in the same cycle.
- frame_err  out  1  one-cycle pulse when the stop bit is sampled low.
- rx_busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset: on rst high at a clk edge, all of the following take effect.
  - sync flops = 1, state = IDLE, baud_cnt = 0, bit_idx = 0, shift = 0.
  - rout = 8'h00, rout_en = 0, frame_err = 0, rx_busy = 0.
  - A reset mid-frame aborts the frame with no pulse.
- Synchroniser: two flops, rx_s = second stage. All decisions use rx_s only, giving 2 cycles of input latency.
- baud_cnt: down-counter of width $clog2(BAUD_DIV). It decrements every cycle outside IDLE, and a "tick" is baud_cnt == 0.
- IDLE:
  - When rx_s == 0: go to START and load baud_cnt = HALF_DIV-1.
  - While rx_s == 1: stay in IDLE.
- START, on tick:
  - If rx_s == 0: go to DATA, load baud_cnt = BAUD_DIV-1, bit_idx = 0.
  - Else (glitch): return to IDLE, with no pulse and no error.
- DATA, on tick:
  - Update shift = {rx_s, shift[7:1]} (LSB first) and reload baud_cnt = BAUD_DIV-1.
  - If bit_idx == 7: go to STOP. Else bit_idx += 1.
- STOP, on tick:
  - If rx_s == 1: rout <= shift, rout_en <= 1 for exactly one cycle, go to IDLE.
  - If rx_s == 0: frame_err <= 1 for one cycle, rout unchanged, go to WAITHI.
- WAITHI: stay until rx_s == 1, then go to IDLE. This covers break conditions and ensures a held-low line never re-triggers a start.
- Latency: rout_en rises one cycle after the stop-bit mid-sample, about 9.5 bit times plus 3 cycles after the start edge on rx_in.
- Back-to-back frames: after a valid stop the block is in IDLE by mid-stop. The next start edge, one half-bit later, is detected normally, so minimum spacing is one stop bit.
- rout_en and frame_err are mutually exclusive and never asserted for more than 1 cycle.
- There is no ready/backpressure: the downstream decoder must accept a byte every rout_en.

Decomposition:
- Shared package uart_pkg holds:
  - state encodings S_IDLE=0, S_START=1, S_DATA=2, S_STOP=3, S_WAITHI=4 (3-bit);
  - default BAUD_DIV;
  - ASCII constants used by the monitor (CR 8'h0d, Ctrl-C 8'h03).
- One natural sub-module: uart_sync2, the 2-flop synchroniser with reset value 1, reusable for other async inputs.
- The FSM, counter and shift register stay in the top module.

Test Plan:
- Run all tests with BAUD_DIV=8.
1. Send 8'h67 ('g') as 1 start, 8 data, 1 stop -> rout=8'h67, rout_en high exactly 1 cycle, frame_err=0, rx_busy low afterwards.
2. Send 8'h03 immediately followed by 8'h0d with no idle gap -> two rout_en pulses with rout 8'h03 then 8'h0d, spaced 10 bit times (80 cycles).
3. Drive rx_in low for 3 cycles (< HALF_DIV), then high -> returns to IDLE, no rout_en, no frame_err, rout unchanged.
4. Send 8'h55 with the stop bit low, hold the line low 40 cycles, then high, then send 8'h31 -> one frame_err pulse, no rout_en for 8'h55, rx_busy high during the hold, then rout=8'h31 with one rout_en.
5. Assert rst for 1 cycle during data bit 4 of 8'hA5, then send 8'h72 -> no output for the aborted frame, all outputs 0 after reset, then rout=8'h72 with rout_en.
6. Send 8'hFF then 8'h00 -> rout values correct; confirms LSB-first ordering and that all-ones and all-zeros data bits do not confuse start/stop detection.
